// File: rtl/vbus_cv_ramp.sv
// Modelled VBUS constant-voltage ramp: a tick-paced slew limiter that moves vbus
// toward dac*MUL, with a dead-band, a discharge path and a settle qualifier.
//
// state   | meaning
// --------+------------------------------------------------
// S_OFF   | gate low, no discharge: vbus frozen
// S_RAMP  | gate high, vbus stepping toward target
// S_HOLD  | gate high, vbus equals target
// S_DISCH | discharge pulling vbus down toward teff
module vbus_cv_ramp #(
  parameter int VW       = 16,
  parameter int MUL      = 10,
  parameter int TICK     = 48,
  parameter int PCT      = 3,
  parameter int DEN      = 100,
  parameter int DBAND    = 33,
  parameter int DSTEP    = 500,
  parameter int SETTLE_N = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [VW-1:0] dac_i,
  input  logic          gate_i,
  input  logic          disch_i,
  output logic [VW-1:0] vbus_o,
  output logic          settled_o,
  output logic          up_o,
  output logic          dn_o,
  output logic          tick_o
);

  localparam int CW = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int SW = $clog2(SETTLE_N + 1);
  localparam logic [VW-1:0] VMAX = '1;

  typedef enum logic [1:0] {S_OFF, S_RAMP, S_HOLD, S_DISCH} state_t;

  logic [CW-1:0]      tcnt_q, tcnt_d;
  logic               tick_q, tick_d;
  logic [VW-1:0]      target_q, target_d;
  logic [VW+7:0]      prod;
  state_t             state_q, state_d;
  logic [VW-1:0]      vbus_q, vbus_d;
  logic               up_q, up_d, dn_q, dn_d;
  logic [SW-1:0]      scnt_q, scnt_d;
  logic [VW-1:0]      teff;
  logic signed [VW:0] delta;
  logic [VW:0]        mag;
  logic [31:0]        slew;
  logic [VW-1:0]      step;
  logic [VW-1:0]      drop;

  // tick_q is high for exactly the cycle whose closing edge applies an update
  always_comb begin
    tcnt_d = (tcnt_q == CW'(TICK - 1)) ? '0 : tcnt_q + CW'(1);
    tick_d = (tcnt_d == CW'(TICK - 1));
  end

  always_comb begin
    prod     = (VW+8)'(dac_i) * (VW+8)'(MUL);
    target_d = (|prod[VW+7:VW]) ? VMAX : prod[VW-1:0];
  end

  always_comb begin
    teff  = gate_i ? target_q : '0;
    delta = $signed({1'b0, teff}) - $signed({1'b0, vbus_q});
    mag   = delta[VW] ? $unsigned(-delta) : $unsigned(delta);
    slew  = (32'(mag) * 32'(PCT)) / 32'(DEN);
    drop  = vbus_q - teff;
    if (32'(mag) <= 32'(DBAND) || slew == 32'd0) begin
      step = VW'(1);
    end else if (slew > 32'(mag)) begin
      step = mag[VW-1:0];
    end else begin
      step = slew[VW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    vbus_d  = vbus_q;
    up_d    = up_q;
    dn_d    = dn_q;
    scnt_d  = scnt_q;
    if (tick_q) begin
      if (disch_i && (vbus_q > teff)) begin
        state_d = S_DISCH;
        vbus_d  = (drop > VW'(DSTEP)) ? vbus_q - VW'(DSTEP) : teff;
      end else if (!gate_i) begin
        state_d = S_OFF;
      end else if (delta == '0) begin
        state_d = S_HOLD;
      end else begin
        state_d = S_RAMP;
        vbus_d  = delta[VW] ? vbus_q - step : vbus_q + step;
      end
      up_d = (vbus_d > vbus_q);
      dn_d = (vbus_d < vbus_q);
      if (vbus_d == teff) begin
        scnt_d = (scnt_q == SW'(SETTLE_N)) ? scnt_q : scnt_q + SW'(1);
      end else begin
        scnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tcnt_q   <= '0;
      tick_q   <= 1'b0;
      target_q <= '0;
      state_q  <= S_OFF;
      vbus_q   <= '0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      scnt_q   <= '0;
    end else begin
      tcnt_q   <= tcnt_d;
      tick_q   <= tick_d;
      target_q <= target_d;
      state_q  <= state_d;
      vbus_q   <= vbus_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      scnt_q   <= scnt_d;
    end
  end

  assign vbus_o    = vbus_q;
  assign up_o      = up_q;
  assign dn_o      = dn_q;
  assign tick_o    = tick_q;
  assign settled_o = (scnt_q == SW'(SETTLE_N));

endmodule

// File: tb/tb_vbus_cv_ramp.sv
// Self-checking bench for vbus_cv_ramp: directed scenarios plus randomized
// input changes, all compared against a tick-level arithmetic reference model.
module tb_vbus_cv_ramp;

  localparam int VW       = 16;
  localparam int MUL      = 10;
  localparam int TICK     = 4;
  localparam int PCT      = 3;
  localparam int DEN      = 100;
  localparam int DBAND    = 33;
  localparam int DSTEP    = 500;
  localparam int SETTLE_N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [VW-1:0] dac = '0;
  logic          gate = 1'b0;
  logic          disch = 1'b0;
  logic [VW-1:0] vbus;
  logic          settled, up, dn, tick;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vbus_cv_ramp #(
    .VW(VW), .MUL(MUL), .TICK(TICK), .PCT(PCT), .DEN(DEN),
    .DBAND(DBAND), .DSTEP(DSTEP), .SETTLE_N(SETTLE_N)
  ) dut (
    .clk_i(clk), .rst_i(rst), .dac_i(dac), .gate_i(gate), .disch_i(disch),
    .vbus_o(vbus), .settled_o(settled), .up_o(up), .dn_o(dn), .tick_o(tick)
  );

  // Reference model: counts edges since reset and applies the update rules
  // with plain integer arithmetic every TICK-th edge.
  int m_cyc, m_tgt, m_vbus, m_settle;
  bit m_up, m_dn, m_upd, m_tick;

  function automatic int next_vbus(input int v, input int tgt, input bit g, input bit d);
    int teff, dl, s;
    teff = g ? tgt : 0;
    if (d && v > teff) return (v - DSTEP > teff) ? v - DSTEP : teff;
    if (!g) return v;
    dl = teff - v;
    if (dl == 0) return v;
    if (dl <= DBAND && dl >= -DBAND) return v + ((dl > 0) ? 1 : -1);
    s = dl * PCT / DEN;
    if (s == 0) s = (dl > 0) ? 1 : -1;
    return v + s;
  endfunction

  always @(posedge clk) begin
    int nv, teff;
    if (rst) begin
      m_cyc = 0; m_tgt = 0; m_vbus = 0; m_settle = 0;
      m_up = 0; m_dn = 0; m_upd = 0; m_tick = 0;
    end else begin
      m_cyc++;
      m_upd = (m_cyc % TICK == 0);
      if (m_upd) begin
        teff = gate ? m_tgt : 0;
        nv = next_vbus(m_vbus, m_tgt, gate, disch);
        m_up = nv > m_vbus;
        m_dn = nv < m_vbus;
        m_settle = (nv == teff) ? ((m_settle < SETTLE_N) ? m_settle + 1 : SETTLE_N) : 0;
        m_vbus = nv;
      end
      m_tick = (m_cyc % TICK == TICK - 1);
      m_tgt = (int'(dac) * MUL > 65535) ? 65535 : int'(dac) * MUL;
    end
  end

  // Advances to the negedge just after the next model update edge.
  task automatic wait_update();
    for (int i = 0; i < 2 * TICK; i++) begin
      @(negedge clk);
      if (m_upd) break;
    end
  endtask

  task automatic settle_at(input int code);
    dac = VW'(code); gate = 1'b1; disch = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (m_upd && m_settle == SETTLE_N) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; dac = 16'd500; gate = 1'b1; disch = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (vbus !== 16'd0) begin n_fail++; $display("FAIL reset_vbus: got %0d want 0", vbus); end
    n_tests++; if (up !== 1'b0) begin n_fail++; $display("FAIL reset_up: got %b want 0", up); end
    n_tests++; if (dn !== 1'b0) begin n_fail++; $display("FAIL reset_dn: got %b want 0", dn); end
    n_tests++; if (settled !== 1'b0) begin n_fail++; $display("FAIL reset_settled: got %b want 0", settled); end
    n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", tick); end
  endtask

  task automatic test_first_ramp();
    rst = 1'b0;
    wait_update();
    n_tests++; if (vbus !== 16'd150) begin n_fail++; $display("FAIL first_tick_vbus: got %0d want 150", vbus); end
    wait_update();
    n_tests++; if (vbus !== 16'd295) begin n_fail++; $display("FAIL second_tick_vbus: got %0d want 295", vbus); end
    n_tests++; if (up !== 1'b1 || dn !== 1'b0) begin n_fail++; $display("FAIL second_tick_dir: got up=%b dn=%b want up=1 dn=0", up, dn); end
  endtask

  task automatic test_deadband();
    settle_at(497);
    n_tests++; if (vbus !== 16'd4970 || settled !== 1'b1) begin n_fail++; $display("FAIL db_start: got vbus=%0d settled=%b want 4970/1", vbus, settled); end
    dac = 16'd500;
    for (int i = 1; i <= 30; i++) begin
      wait_update();
      n_tests++; if (vbus !== 16'(4970 + i) || up !== 1'b1) begin n_fail++; $display("FAIL db_step%0d: got vbus=%0d up=%b want %0d/1", i, vbus, up, 4970 + i); end
    end
    n_tests++; if (settled !== 1'b0) begin n_fail++; $display("FAIL db_not_settled: got %b want 0", settled); end
    repeat (4) wait_update();
    n_tests++; if (vbus !== 16'd5000 || settled !== 1'b1 || up !== 1'b0) begin n_fail++; $display("FAIL db_settled: got vbus=%0d settled=%b up=%b want 5000/1/0", vbus, settled, up); end
  endtask

  task automatic test_discharge();
    settle_at(500);
    gate = 1'b0; disch = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      wait_update();
      n_tests++; if (vbus !== 16'(5000 - 500 * i) || dn !== 1'b1) begin n_fail++; $display("FAIL dis_step%0d: got vbus=%0d dn=%b want %0d/1", i, vbus, dn, 5000 - 500 * i); end
    end
    repeat (2) wait_update();
    n_tests++; if (vbus !== 16'd0 || dn !== 1'b0 || up !== 1'b0) begin n_fail++; $display("FAIL dis_floor: got vbus=%0d up=%b dn=%b want 0/0/0", vbus, up, dn); end
    disch = 1'b0;
  endtask

  task automatic test_disch_to_target();
    settle_at(500);
    dac = 16'd300; disch = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wait_update();
      n_tests++; if (vbus !== 16'(5000 - 500 * i) || dn !== 1'b1) begin n_fail++; $display("FAIL dt_step%0d: got vbus=%0d dn=%b want %0d/1", i, vbus, dn, 5000 - 500 * i); end
    end
    wait_update();
    n_tests++; if (vbus !== 16'd3000 || up !== 1'b0 || dn !== 1'b0) begin n_fail++; $display("FAIL dt_hold: got vbus=%0d up=%b dn=%b want 3000/0/0", vbus, up, dn); end
    disch = 1'b0;
  endtask

  task automatic test_gate_fall_disch();
    settle_at(300);
    gate = 1'b0; disch = 1'b1;
    wait_update();
    n_tests++; if (vbus !== 16'd2500 || dn !== 1'b1) begin n_fail++; $display("FAIL gf_disch: got vbus=%0d dn=%b want 2500/1", vbus, dn); end
    wait_update();
    n_tests++; if (vbus !== 16'd2000) begin n_fail++; $display("FAIL gf_disch2: got %0d want 2000", vbus); end
    disch = 1'b0;
  endtask

  task automatic test_saturation();
    dac = 16'hFFFF; gate = 1'b1; disch = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (m_upd) begin
        n_tests++; if (vbus !== 16'(m_vbus)) begin n_fail++; $display("FAIL sat_track: got %0d want %0d", vbus, m_vbus); end
        if (m_vbus == 65535) break;
      end
    end
    n_tests++; if (vbus !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %0d want 65535", vbus); end
    repeat (2) wait_update();
    n_tests++; if (vbus !== 16'hFFFF || up !== 1'b0 || dn !== 1'b0) begin n_fail++; $display("FAIL sat_hold: got vbus=%0d up=%b dn=%b want 65535/0/0", vbus, up, dn); end
  endtask

  task automatic test_reset_mid_ramp();
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    dac = 16'd1000; gate = 1'b1; disch = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (m_vbus >= 2000) break;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (vbus !== 16'd0 || settled !== 1'b0 || up !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("FAIL rst_mid: got vbus=%0d settled=%b up=%b tick=%b want 0/0/0/0", vbus, settled, up, tick); end
    for (int i = 1; i <= TICK + 1; i++) begin
      @(negedge clk);
      n_tests++; if (vbus !== ((i < TICK) ? 16'd0 : 16'd300)) begin n_fail++; $display("FAIL rst_first_upd c%0d: got %0d want %0d", i, vbus, (i < TICK) ? 0 : 300); end
      n_tests++; if (tick !== m_tick) begin n_fail++; $display("FAIL rst_tick c%0d: got %b want %b", i, tick, m_tick); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      n_tests++; if (vbus !== 16'(m_vbus)) begin n_fail++; $display("FAIL rnd_vbus c%0d: got %0d want %0d", c, vbus, m_vbus); end
      n_tests++; if (up !== m_up || dn !== m_dn) begin n_fail++; $display("FAIL rnd_dir c%0d: got up=%b dn=%b want %b/%b", c, up, dn, m_up, m_dn); end
      n_tests++; if (settled !== (m_settle == SETTLE_N)) begin n_fail++; $display("FAIL rnd_settled c%0d: got %b want %b", c, settled, m_settle == SETTLE_N); end
      n_tests++; if (tick !== m_tick) begin n_fail++; $display("FAIL rnd_tick c%0d: got %b want %b", c, tick, m_tick); end
      if ($urandom_range(0, 59) == 0) begin
        case ($urandom_range(0, 3))
          0: dac = 16'hFFFF;
          1: dac = VW'($urandom_range(0, 6553));
          default: dac = VW'($urandom_range(0, 700));
        endcase
      end
      if ($urandom_range(0, 39) == 0) gate = ~gate;
      if ($urandom_range(0, 39) == 0) disch = ~disch;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_ramp();
    test_deadband();
    test_discharge();
    test_disch_to_target();
    test_gate_fall_disch();
    test_saturation();
    test_reset_mid_ramp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vbus_cv_ramp.md
VBUS_CV_RAMP -- requirements
Module: vbus_cv_ramp

Interface
REQ-001 Parameter VW, 16: width of the DAC code, target and VBUS value in mV.
REQ-002 Parameter MUL, 10: CV loop gain; target = dac × MUL.
REQ-003 Parameter TICK, 48: clk cycles per update tick; legal range ≥1.
REQ-004 Parameter PCT, 3 and DEN, 100: slew fraction, step = delta × PCT / DEN.
REQ-005 Parameter DBAND, 33: dead-band in mV; inside it the step is ±1.
REQ-006 Parameter DSTEP, 500: discharge step in mV per tick.
REQ-007 Parameter SETTLE_N, 4: consecutive on-target ticks required for settled.
REQ-008 clk  in  1  single clock; all state changes on its rising edge.
REQ-009 rst  in  1  reset, synchronous, active-high.
REQ-010 dac  in  VW  CV DAC code.
REQ-011 gate  in  1  power-path enable (PWR_ENABLE).
REQ-012 disch  in  1  VBUS discharge request.
REQ-013 vbus  out  VW  modelled VBUS in mV.
REQ-014 settled  out  1  vbus has equalled the effective target for SETTLE_N ticks.
REQ-015 up  out  1  the last tick raised vbus.
REQ-016 dn  out  1  the last tick lowered vbus.
REQ-017 tick  out  1  one-cycle pulse on each update cycle.

Function
REQ-018 The tick counter SHALL count 0..TICK-1, wrap to 0, and pulse tick when it reaches TICK-1; it runs whenever rst=0.
REQ-019 The target SHALL be dac × MUL, computed at width VW+8 and saturated to 2^VW-1, registered every cycle, so a dac change reaches the update path 1 cycle later.
REQ-020 The effective target teff SHALL equal target when gate=1 and 0 when gate=0.
REQ-021 delta SHALL be teff − vbus, signed, VW+1 bits.
REQ-022 The state machine SHALL have the states OFF, RAMP, HOLD and DISCH, evaluated on tick cycles only.
REQ-023 DISCH SHALL be entered when disch=1 and vbus>teff: vbus −= DSTEP, clamped so that vbus never goes below teff.
REQ-024 OFF SHALL be entered when gate=0 and disch=0: vbus holds its value, with no decay.
REQ-025 RAMP SHALL be entered when gate=1 and delta≠0:
- if 0<|delta|≤DBAND, vbus moves ±1 toward teff;
- otherwise vbus moves by delta × PCT / DEN, truncated toward zero, with magnitude at least 1.
REQ-026 vbus SHALL never overshoot teff and never wrap below 0 or above 2^VW-1.
REQ-027 HOLD SHALL be entered when gate=1 and delta=0: vbus is unchanged.
REQ-028 Priority SHALL be DISCH > OFF > RAMP/HOLD.
REQ-029 disch=1 with vbus≤teff SHALL use the gate rules of REQ-024, REQ-025 and REQ-027.
REQ-030 up and dn SHALL update on each tick to reflect the sign of that tick's change and hold between ticks; both are 0 when the tick made no change.
REQ-031 A settle counter SHALL increment, saturating at SETTLE_N, on each tick ending with vbus==teff, and clear on any tick ending otherwise.
REQ-032 settled SHALL equal (settle counter == SETTLE_N).
REQ-033 A dac, gate or disch change between ticks SHALL take effect at the next tick only; only the latest value at that tick is used.
REQ-034 Simultaneous gate fall and disch rise at a tick SHALL be handled as DISCH toward 0.

Reset
REQ-035 While rst=1 at a clk edge, the following SHALL be reset: vbus=0, up=0, dn=0, settled=0, tick=0, tick counter=0, settle counter=0, registered target=0, state=OFF.
REQ-036 Reset asserted mid-ramp SHALL abort the ramp; after rst falls, the first tick occurs TICK cycles later.

Verification
REQ-037 Scenario: defaults, TICK=4, gate=1, dac=500 from reset -> first tick vbus=150, second tick vbus=295, up=1.
REQ-038 Scenario: vbus=4970, target 5000 -> successive ticks give 4971, 4972, …, 5000; settled=1 after 4 further on-target ticks.
REQ-039 Scenario: vbus=5000, gate=0, disch=1 -> 4500, 4000, …, 0 on successive ticks, then holds 0, dn=0, no underflow.
REQ-040 Scenario: vbus=5000, dac set 300 (target 3000), disch=1 -> 4500, 4000, 3500, 3000, then HOLD.
REQ-041 Scenario: dac=16'hFFFF -> target saturates at 65535; vbus reaches 65535 with no wrap.
REQ-042 Scenario: rst pulsed for 1 cycle at vbus≈2000 mid-ramp -> next cycle vbus=0 and settled=0; tick reappears exactly TICK cycles after rst falls.
